// File: rtl/regfile_wb_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_queue_pkg
// Description : Shared types and constants for the register-file write-back
//               queue: register address width, zero-register index and the
//               queue entry record {rd, data}.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_wb_queue_pkg;

    localparam int unsigned REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;

    // Writes addressed to this register are architecturally discarded.
    localparam reg_addr_t REG_ZERO = '0;

    // Default data width of a queue entry; the queue itself re-declares the
    // same {rd, data} layout at its own WIDTH.
    localparam int unsigned WB_DATA_W = 32;

    typedef struct packed {
        reg_addr_t              rd;
        logic [WB_DATA_W-1:0]   data;
    } wb_entry_t;

endpackage : regfile_wb_queue_pkg
`default_nettype wire

// File: rtl/wb_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo_mem
// Description : DEPTH x ENTRY_W storage array with two write ports (ALU and
//               multdiv sources) and one asynchronous read port. Holds no
//               pointer or occupancy state.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo_mem #(
    parameter  int unsigned DEPTH   = 4,
    parameter  int unsigned ENTRY_W = 37,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we_a_i,
    input  logic [AW-1:0]      waddr_a_i,
    input  logic [ENTRY_W-1:0] wdata_a_i,
    input  logic               we_b_i,
    input  logic [AW-1:0]      waddr_b_i,
    input  logic [ENTRY_W-1:0] wdata_b_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [ENTRY_W-1:0] rdata_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    // Per-entry write; the controller never targets one slot from both ports.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (we_a_i && (waddr_a_i == AW'(i))) begin
                mem_q[i] <= wdata_a_i;
            end else if (we_b_i && (waddr_b_i == AW'(i))) begin
                mem_q[i] <= wdata_b_i;
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : wb_fifo_mem
`default_nettype wire

// File: rtl/regfile_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_queue
// Description : Merges ALU and multdiv results into a circular FIFO and drains
//               one entry per cycle into the register-file write port. Raises
//               stall when fewer than two free slots remain and records any
//               result dropped while stalled in a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_queue
    import regfile_wb_queue_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4     // power of two, >= 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              alu_valid,
    input  logic [4:0]        alu_rd,
    input  logic [WIDTH-1:0]  alu_data,
    input  logic              md_valid,
    input  logic [4:0]        md_rd,
    input  logic [WIDTH-1:0]  md_data,
    output logic              stall,
    output logic              ctrl_writeEnable,
    output logic [4:0]        ctrl_writeReg,
    output logic [WIDTH-1:0]  data_writeReg,
    output logic              overflow
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = REG_AW + WIDTH;

    // Same layout as wb_entry_t, widened to this instance's WIDTH.
    typedef struct packed {
        reg_addr_t          rd;
        logic [WIDTH-1:0]   data;
    } entry_t;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             wen_q, wen_d;
    reg_addr_t        wreg_q, wreg_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;

    logic             alu_push, md_push, pop;
    logic [PTR_W-1:0] md_waddr;
    entry_t           alu_entry, md_entry, head_entry;

    // Stall comes from registered occupancy only, so it never depends on inputs.
    assign stall = (count_q > CNT_W'(DEPTH - 2));

    assign alu_push = alu_valid && !stall && (alu_rd != REG_ZERO);
    assign md_push  = md_valid  && !stall && (md_rd  != REG_ZERO);
    assign pop      = (count_q != '0);

    // ALU result takes the tail slot; multdiv lands behind it when both push.
    assign md_waddr  = alu_push ? (tail_q + PTR_W'(1)) : tail_q;
    assign alu_entry = '{rd: alu_rd, data: alu_data};
    assign md_entry  = '{rd: md_rd,  data: md_data};

    wb_fifo_mem #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_mem (
        .clk       (clk),
        .we_a_i    (alu_push),
        .waddr_a_i (tail_q),
        .wdata_a_i (alu_entry),
        .we_b_i    (md_push),
        .waddr_b_i (md_waddr),
        .wdata_b_i (md_entry),
        .raddr_i   (head_q),
        .rdata_o   (head_entry)
    );

    // Next-state for pointers, occupancy, write-port registers and overflow.
    always_comb begin
        head_d     = head_q + PTR_W'(pop);
        tail_d     = tail_q + PTR_W'(alu_push) + PTR_W'(md_push);
        count_d    = count_q + CNT_W'(alu_push) + CNT_W'(md_push) - CNT_W'(pop);
        overflow_d = overflow_q | ((alu_valid | md_valid) & stall);
        wen_d      = pop;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        if (pop) begin
            wreg_d  = head_entry.rd;
            wdata_d = head_entry.data;
        end
    end

    // State registers; clr discards queued entries and clears the write port.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            wen_q      <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            wen_q      <= wen_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
        end
    end

    assign ctrl_writeEnable = wen_q;
    assign ctrl_writeReg    = wreg_q;
    assign data_writeReg    = wdata_q;
    assign overflow         = overflow_q;

endmodule : regfile_wb_queue
`default_nettype wire

// File: tb/tb_regfile_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_queue
// Description : Directed self-checking bench for regfile_wb_queue
//               (WIDTH=32, DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_queue;

    logic        clk;
    logic        clr;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        stall;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        overflow;

    int total;
    int passed;

    regfile_wb_queue #(
        .WIDTH (32),
        .DEPTH (4)
    ) dut (
        .clk              (clk),
        .clr              (clr),
        .alu_valid        (alu_valid),
        .alu_rd           (alu_rd),
        .alu_data         (alu_data),
        .md_valid         (md_valid),
        .md_rd            (md_rd),
        .md_data          (md_data),
        .stall            (stall),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .overflow         (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        md_valid  = 1'b0; md_rd  = '0; md_data  = '0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        total++; if (ctrl_writeEnable !== 1'b0) $display("FAIL reset_we got=%b exp=0", ctrl_writeEnable); else passed++;
        total++; if (ctrl_writeReg !== 5'd0) $display("FAIL reset_reg got=%0d exp=0", ctrl_writeReg); else passed++;
        total++; if (data_writeReg !== 32'd0) $display("FAIL reset_data got=%h exp=0", data_writeReg); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", overflow); else passed++;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_single_write();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        idle_inputs();
        total++; if (ctrl_writeEnable !== 1'b0) $display("FAIL single_we_early got=%b exp=0", ctrl_writeEnable); else passed++;
        tick();
        total++; if (ctrl_writeEnable !== 1'b1) $display("FAIL single_we got=%b exp=1", ctrl_writeEnable); else passed++;
        total++; if (ctrl_writeReg !== 5'd5) $display("FAIL single_reg got=%0d exp=5", ctrl_writeReg); else passed++;
        total++; if (data_writeReg !== 32'hDEADBEEF) $display("FAIL single_data got=%h exp=deadbeef", data_writeReg); else passed++;
        tick();
        total++; if (ctrl_writeEnable !== 1'b0) $display("FAIL single_we_after got=%b exp=0", ctrl_writeEnable); else passed++;
        total++; if (data_writeReg !== 32'hDEADBEEF) $display("FAIL single_data_hold got=%h exp=deadbeef", data_writeReg); else passed++;
    endtask

    task automatic test_same_rd_order();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
        md_valid  = 1'b1; md_rd  = 5'd3; md_data  = 32'h22;
        tick();
        idle_inputs();
        tick();
        total++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd3, 32'h11})
            $display("FAIL samerd_first got=%b/%0d/%h exp=1/3/11", ctrl_writeEnable, ctrl_writeReg, data_writeReg); else passed++;
        tick();
        total++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd3, 32'h22})
            $display("FAIL samerd_second got=%b/%0d/%h exp=1/3/22", ctrl_writeEnable, ctrl_writeReg, data_writeReg); else passed++;
        tick();
        total++; if ({ctrl_writeEnable, data_writeReg} !== {1'b0, 32'h22})
            $display("FAIL samerd_final got=%b/%h exp=0/22", ctrl_writeEnable, data_writeReg); else passed++;
    endtask

    task automatic test_rd_zero();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
        tick();
        idle_inputs();
        total++; if (ctrl_writeEnable !== 1'b0) $display("FAIL rdzero_we1 got=%b exp=0", ctrl_writeEnable); else passed++;
        tick();
        total++; if (ctrl_writeEnable !== 1'b0) $display("FAIL rdzero_we2 got=%b exp=0", ctrl_writeEnable); else passed++;
        total++; if (data_writeReg !== 32'h22) $display("FAIL rdzero_hold got=%h exp=22", data_writeReg); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL rdzero_stall got=%b exp=0", stall); else passed++;
    endtask

    task automatic test_overflow();
        logic [4:0]  got_rd[$];
        logic [31:0] got_data[$];
        logic [4:0]  exp_rd[6];
        logic [31:0] exp_data[6];
        exp_rd   = '{5'd1, 5'd10, 5'd2, 5'd11, 5'd4, 5'd13};
        exp_data = '{32'hA0000000, 32'hB0000000, 32'hA0000001, 32'hB0000001, 32'hA0000003, 32'hB0000003};
        for (int i = 0; i < 10; i++) begin
            if (i < 4) begin
                alu_valid = 1'b1; alu_rd = 5'(1 + i);  alu_data = 32'hA0000000 + 32'(i);
                md_valid  = 1'b1; md_rd  = 5'(10 + i); md_data  = 32'hB0000000 + 32'(i);
            end else begin
                idle_inputs();
            end
            tick();
            if (ctrl_writeEnable === 1'b1) begin
                got_rd.push_back(ctrl_writeReg);
                got_data.push_back(data_writeReg);
            end
            if (i == 0) begin
                total++; if (stall !== 1'b0) $display("FAIL ovf_stall_e1 got=%b exp=0", stall); else passed++;
            end
            if (i == 1) begin
                total++; if (stall !== 1'b1) $display("FAIL ovf_stall_e2 got=%b exp=1", stall); else passed++;
                total++; if (overflow !== 1'b0) $display("FAIL ovf_early got=%b exp=0", overflow); else passed++;
            end
            if (i == 2) begin
                total++; if (overflow !== 1'b1) $display("FAIL ovf_set got=%b exp=1", overflow); else passed++;
                total++; if (stall !== 1'b0) $display("FAIL ovf_stall_e3 got=%b exp=0", stall); else passed++;
            end
        end
        total++; if (got_rd.size() !== 6) $display("FAIL ovf_count got=%0d exp=6", got_rd.size()); else passed++;
        for (int k = 0; k < 6; k++) begin
            if (k < got_rd.size()) begin
                total++; if ({got_rd[k], got_data[k]} !== {exp_rd[k], exp_data[k]})
                    $display("FAIL ovf_order[%0d] got=%0d/%h exp=%0d/%h", k, got_rd[k], got_data[k], exp_rd[k], exp_data[k]); else passed++;
            end
        end
        total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", overflow); else passed++;
    endtask

    task automatic test_clear_mid();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        md_valid  = 1'b1; md_rd  = 5'd8; md_data  = 32'h88;
        tick();
        alu_rd = 5'd9;  alu_data = 32'h99;
        md_rd  = 5'd12; md_data  = 32'hCC;
        tick();
        idle_inputs();
        total++; if ({ctrl_writeEnable, ctrl_writeReg, stall} !== {1'b1, 5'd7, 1'b1})
            $display("FAIL clr_pre got=%b/%0d/%b exp=1/7/1", ctrl_writeEnable, ctrl_writeReg, stall); else passed++;
        #2;
        clr = 1'b1;
        #1;
        total++; if (ctrl_writeEnable !== 1'b0) $display("FAIL clr_we got=%b exp=0", ctrl_writeEnable); else passed++;
        total++; if ({ctrl_writeReg, data_writeReg} !== 37'd0) $display("FAIL clr_outs got=%0d/%h exp=0/0", ctrl_writeReg, data_writeReg); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL clr_stall got=%b exp=0", stall); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL clr_overflow got=%b exp=0", overflow); else passed++;
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (ctrl_writeEnable !== 1'b0) $display("FAIL clr_nowrite[%0d] got=%b exp=0", i, ctrl_writeEnable); else passed++;
        end
        // Release again with a result already waiting for the first edge.
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
        tick();
        idle_inputs();
        total++; if (ctrl_writeEnable !== 1'b0) $display("FAIL first_enq_early got=%b exp=0", ctrl_writeEnable); else passed++;
        tick();
        total++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd6, 32'h66})
            $display("FAIL first_enq got=%b/%0d/%h exp=1/6/66", ctrl_writeEnable, ctrl_writeReg, data_writeReg); else passed++;
        tick();
    endtask

    task automatic test_wrap();
        logic [4:0]  got_rd[$];
        logic [31:0] got_data[$];
        int          stall_seen;
        stall_seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (i < 12) begin
                alu_valid = 1'b1; alu_rd = 5'((i % 31) + 1); alu_data = 32'h100 + 32'(i);
            end else begin
                idle_inputs();
            end
            tick();
            if (stall !== 1'b0) stall_seen++;
            if (ctrl_writeEnable === 1'b1) begin
                got_rd.push_back(ctrl_writeReg);
                got_data.push_back(data_writeReg);
            end
        end
        total++; if (stall_seen !== 0) $display("FAIL wrap_stall got=%0d cycles exp=0", stall_seen); else passed++;
        total++; if (got_rd.size() !== 12) $display("FAIL wrap_count got=%0d exp=12", got_rd.size()); else passed++;
        for (int k = 0; k < 12; k++) begin
            if (k < got_rd.size()) begin
                total++; if ({got_rd[k], got_data[k]} !== {5'(k + 1), 32'h100 + 32'(k)})
                    $display("FAIL wrap_order[%0d] got=%0d/%h exp=%0d/%h", k, got_rd[k], got_data[k], k + 1, 32'h100 + k); else passed++;
            end
        end
    endtask

    initial begin
        total  = 0;
        passed = 0;
        test_reset();
        test_single_write();
        test_same_rd_order();
        test_rd_zero();
        test_overflow();
        test_clear_mid();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_regfile_wb_queue
`default_nettype wire

// File: doc/regfile_wb_queue.md
REGFILE_WB_QUEUE -- requirements
Module: regfile_wb_queue

Interface
REQ-001 Parameter WIDTH, default 32, data word width written to the register file.
REQ-002 Parameter DEPTH, default 4, queue entries; power of two, minimum 4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-high.
REQ-005 alu_valid  input  1  ALU-path result present this cycle.
REQ-006 alu_rd  input  5  ALU-path destination register.
REQ-007 alu_data  input  WIDTH  ALU-path result.
REQ-008 md_valid  input  1  multdiv-path result present this cycle; single-cycle pulse.
REQ-009 md_rd  input  5  multdiv-path destination register.
REQ-010 md_data  input  WIDTH  multdiv-path result.
REQ-011 stall  output  1  queue cannot guarantee two free slots; upstream holds its valids low.
REQ-012 ctrl_writeEnable  output  1  register-file write strobe.
REQ-013 ctrl_writeReg  output  5  register-file write address.
REQ-014 data_writeReg  output  WIDTH  register-file write data.
REQ-015 overflow  output  1  sticky; a valid result arrived while stall was high.

Function
REQ-016 Entries with rd == 0 are discarded, never enqueued, never written.
REQ-017 Both valids in one cycle: ALU entry enqueued ahead of multdiv entry.
REQ-018 Queue is a circular FIFO of {rd, data}; head/tail pointers wrap modulo DEPTH.
REQ-019 Each edge with count > 0 (count as registered before the edge): head popped into output registers, ctrl_writeEnable = 1 for the following cycle.
REQ-020 Each edge with count == 0: ctrl_writeEnable = 0; ctrl_writeReg and data_writeReg hold their last values.
REQ-021 Enqueue and dequeue in the same cycle are legal; count_next = count + pushes - pop.
REQ-022 Latency: result presented at edge N into an empty queue appears on write outputs in the cycle after edge N+1; no combinational path from inputs to write outputs.
REQ-023 stall = (count > DEPTH-2), decoded from registered count only.
REQ-024 Valids asserted while stall = 1 are dropped; overflow set at that edge and held until reset.
REQ-025 Order preserved: writes reach the register file in enqueue order; same-rd writes are never reordered.
REQ-026 count never exceeds DEPTH; pointers never pass each other.

Reset
REQ-027 clr asserted: count, head, tail = 0; ctrl_writeEnable = 0; ctrl_writeReg = 0; data_writeReg = 0; overflow = 0; stall = 0, all immediately and independent of clk.
REQ-028 clr mid-operation discards all queued entries; no write strobe is emitted for them after release.
REQ-029 First enqueue is accepted at the first rising edge with clr low.

Structure
REQ-030 Shared package holds the register-address width (5), the zero-register index, and the queue entry record {rd, data}.
REQ-031 One sub-module, wb_fifo_mem: DEPTH x (5+WIDTH) storage, one write port per source, one read port; all pointer and count logic stays in regfile_wb_queue.

Verification
REQ-032 Single ALU write rd=5, data=0xDEADBEEF into empty queue at edge 1 -> ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF in cycle after edge 2; enable low after.
REQ-033 Simultaneous alu(rd=3,0x11) and md(rd=3,0x22) -> two consecutive writes to r3, 0x11 then 0x22; final r3 value 0x22.
REQ-034 alu_rd=0 with data 0xFFFFFFFF -> no write strobe, count unchanged.
REQ-035 Dual pushes every cycle from empty (DEPTH=4) -> stall rises once count reaches 3; further valids while stall=1 set overflow; order of accepted writes intact.
REQ-036 Three entries queued, clr pulsed mid-cycle -> outputs 0 immediately, no write strobes after release, stall=0.
REQ-037 Continuous single pushes for 3*DEPTH cycles -> pointers wrap, every entry written exactly once in order, stall never asserted.
